// File: rtl/synth_pkg.sv
// Shared types and default constants for the synthesizer record/playback path.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } lr_state_t;

    localparam int SAMPLE_W      = 16;
    localparam int ADDR_W        = 23;
    localparam int TICK_DIV_44K1 = 2268;

endpackage

// File: rtl/sample_tick.sv
// Free-running sample-rate strobe: counts 0..DIV-1, tick high while the count is DIV-1.
// Latency: tick is decoded from the registered count, DIV cycles between strobes.
// Backpressure: none; the strobe never stalls.
module sample_tick #(
    parameter int DIV = synth_pkg::TICK_DIV_44K1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/loop_recorder.sv
// Record/loop-playback sequencer: one RAM write (record) or read (play) per sample tick.
// Latency: mem_req rises the cycle after tick; sample_out updates the cycle after mem_ack.
// Backpressure: one request in flight; a tick arriving while it is outstanding is dropped and flags overrun.
module loop_recorder #(
    parameter int ADDR_W   = synth_pkg::ADDR_W,
    parameter int SAMPLE_W = synth_pkg::SAMPLE_W,
    parameter int DIV      = synth_pkg::TICK_DIV_44K1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rec,
    input  logic                play,
    input  logic [SAMPLE_W-1:0] sig_in,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [SAMPLE_W-1:0] mem_wdata,
    input  logic                mem_ack,
    input  logic [SAMPLE_W-1:0] mem_rdata,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic [ADDR_W-1:0]   loop_len,
    output logic                overrun
);
    import synth_pkg::*;

    localparam logic [ADDR_W-1:0] LEN_MAX = '1;

    lr_state_t           state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   loop_len_q, loop_len_d, addr_q, addr_d;
    logic [SAMPLE_W-1:0] wdata_q, wdata_d, sample_q, sample_d;
    logic                req_q, req_d, we_q, we_d, valid_q, valid_d;
    logic                overrun_q, overrun_d, full_q, full_d;
    logic                tick, ack;
    logic [ADDR_W-1:0]   wr_next, rd_next;

    sample_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign ack     = mem_ack && req_q;
    assign wr_next = wr_addr_q + 1'b1;
    assign rd_next = rd_addr_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        loop_len_d = loop_len_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sample_d   = sample_q;
        req_d      = req_q;
        we_d       = we_q;
        valid_d    = 1'b0;
        overrun_d  = overrun_q;
        // A full recording blocks re-entry until rec is released.
        full_d     = full_q && rec;

        if (ack) begin
            req_d = 1'b0;
            if (we_q) begin
                wr_addr_d  = wr_next;
                loop_len_d = wr_next;
                if (wr_next == LEN_MAX) begin
                    state_d = IDLE;
                    full_d  = 1'b1;
                end
            end else begin
                sample_d  = mem_rdata;
                valid_d   = 1'b1;
                rd_addr_d = (rd_next == loop_len_q) ? '0 : rd_next;
            end
        end

        if (tick) begin
            if (req_q) begin
                overrun_d = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rec) begin
                            if (!full_q) begin
                                state_d    = RECORD;
                                wr_addr_d  = '0;
                                loop_len_d = '0;
                                req_d      = 1'b1;
                                we_d       = 1'b1;
                                addr_d     = '0;
                                wdata_d    = sig_in;
                            end
                        end else if (play && (loop_len_q != '0)) begin
                            state_d   = PLAY;
                            rd_addr_d = '0;
                            req_d     = 1'b1;
                            we_d      = 1'b0;
                            addr_d    = '0;
                        end
                    end
                    RECORD: begin
                        if (!rec) begin
                            state_d = IDLE;
                        end else begin
                            req_d   = 1'b1;
                            we_d    = 1'b1;
                            addr_d  = wr_addr_q;
                            wdata_d = sig_in;
                        end
                    end
                    PLAY: begin
                        if (!play || rec) begin
                            state_d  = IDLE;
                            sample_d = '0;
                        end else begin
                            req_d  = 1'b1;
                            we_d   = 1'b0;
                            addr_d = rd_addr_q;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            loop_len_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sample_q   <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            loop_len_q <= loop_len_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sample_q   <= sample_d;
            req_q      <= req_d;
            we_q       <= we_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            full_q     <= full_d;
        end
    end

    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign loop_len     = loop_len_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_loop_recorder.sv
// Bench for loop_recorder with a small-word RAM model and a tick-level reference model.
module tb_loop_recorder;
    localparam int AW = 4;
    localparam int SW = 16;
    localparam int DV = 8;

    logic          clk = 1'b0;
    logic          rst, rec, play;
    logic [SW-1:0] sig_in;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_wdata, mem_rdata, sample_out;
    logic          sample_valid, overrun;
    logic [AW-1:0] loop_len;

    loop_recorder #(.ADDR_W(AW), .SAMPLE_W(SW), .DIV(DV)) dut (
        .clk(clk), .rst(rst), .rec(rec), .play(play), .sig_in(sig_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .sample_out(sample_out),
        .sample_valid(sample_valid), .loop_len(loop_len), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Tick position as the bench expects it: DIV-cycle period restarting at reset.
    int tcnt = 0;
    always @(posedge clk) tcnt <= rst ? 0 : ((tcnt == DV - 1) ? 0 : tcnt + 1);

    // RAM model: acks a fixed number of negedges after a new request is seen.
    logic [SW-1:0] ram [16];
    logic [19:0]   wr_log[$];
    int            rd_log[$];
    logic [SW-1:0] out_q[$];
    int            req_rises = 0;
    logic          stall_next = 1'b0;
    logic          stray_ack  = 1'b0;

    initial begin
        int lat_cnt;
        int cur_lat;
        logic          cap_we;
        logic [AW-1:0] cap_addr;
        logic [SW-1:0] cap_wdata;
        lat_cnt = 0; cur_lat = 3; cap_we = 1'b0; cap_addr = '0; cap_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 16; i++) ram[i] = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                lat_cnt = 0;
            end else if (mem_req) begin
                if (lat_cnt == 0) begin
                    cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
                    cur_lat = stall_next ? 13 : 3;
                    stall_next = 1'b0;
                    req_rises++;
                end
                lat_cnt++;
                if (lat_cnt == cur_lat) begin
                    check("hs_stable", 32'({mem_we, mem_addr, mem_wdata} == {cap_we, cap_addr, cap_wdata}), 32'd1);
                    if (mem_we) begin
                        ram[mem_addr] = mem_wdata;
                        wr_log.push_back({mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = ram[mem_addr];
                        rd_log.push_back(int'(mem_addr));
                    end
                    mem_ack = 1'b1;
                end
            end else begin
                lat_cnt = 0;
                if (stray_ack) begin
                    mem_rdata = 16'hDEAD;
                    mem_ack   = 1'b1;
                    stray_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sample_valid) out_q.push_back(sample_out);
        end
    end

    task automatic wait_tick();
        do begin
            @(posedge clk);
            #1;
        end while (tcnt != DV - 1);
    endtask

    task automatic apply(input logic r, input logic p, input logic [SW-1:0] s);
        wait_tick();
        rec = r; play = p; sig_in = s;
    endtask

    task automatic do_reset();
        rst = 1'b1; rec = 1'b0; play = 1'b0; sig_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic clear_logs();
        wr_log.delete(); rd_log.delete(); out_q.delete(); req_rises = 0;
    endtask

    typedef struct {
        logic          r;
        logic          p;
        logic [SW-1:0] s;
        logic [AW-1:0] len;
        logic [SW-1:0] out;
    } vec_t;

    vec_t          tv [19];
    logic [SW-1:0] exp_rec[$];

    initial begin
        int            m_mode, m_len, m_idx;
        bit            m_full;
        logic [SW-1:0] m_list[$];
        logic [19:0]   m_wr[$];
        logic [SW-1:0] m_out[$];
        logic          r, p;
        logic [SW-1:0] s;

        // Record 5, idle one tick, play 12, stop.
        for (int n = 0; n < 19; n++) begin
            tv[n].r   = (n < 5);
            tv[n].p   = (n >= 6 && n < 18);
            tv[n].s   = (n < 5) ? 16'(16'h1000 + n) : 16'h0;
            tv[n].len = (n < 5) ? 4'(n + 1) : 4'd5;
            tv[n].out = (n >= 6 && n < 18) ? 16'(16'h1000 + (n - 6) % 5) : 16'h0;
        end

        do_reset();
        check("rst_req", 32'(mem_req), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_out", 32'(sample_out), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_len", 32'(loop_len), 0);
        check("rst_overrun", 32'(overrun), 0);

        clear_logs();
        for (int i = 0; i < 19; i++) begin
            wait_tick();
            if (i > 0) begin
                check("t1_len", 32'(loop_len), 32'(tv[i-1].len));
                check("t1_out", 32'(sample_out), 32'(tv[i-1].out));
            end
            rec = tv[i].r; play = tv[i].p; sig_in = tv[i].s;
        end
        wait_tick();
        check("t1_len_end", 32'(loop_len), 32'(tv[18].len));
        check("t1_out_end", 32'(sample_out), 32'(tv[18].out));
        check("t1_nwr", 32'(wr_log.size()), 5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++)
            check("t1_wr", 32'(wr_log[i]), 32'({4'(i), 16'(16'h1000 + i)}));
        check("t1_nrd", 32'(rd_log.size()), 12);
        for (int i = 0; i < 12 && i < rd_log.size(); i++)
            check("t1_rd_addr", 32'(rd_log[i]), 32'(i % 5));
        check("t1_nvalid", 32'(out_q.size()), 12);

        // Play with nothing recorded, then a stray ack.
        do_reset();
        clear_logs();
        apply(1'b0, 1'b1, 16'h0);
        apply(1'b0, 1'b1, 16'h0);
        apply(1'b0, 1'b1, 16'h0);
        apply(1'b0, 1'b0, 16'h0);
        check("t2_no_req", 32'(req_rises), 0);
        check("t2_out", 32'(sample_out), 0);
        check("t2_len", 32'(loop_len), 0);
        stray_ack = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t2_stray_valid", 32'(out_q.size()), 0);
        check("t2_stray_out", 32'(sample_out), 0);
        check("t2_stray_req", 32'(mem_req), 0);

        // Hold rec past the capacity of the RAM.
        do_reset();
        clear_logs();
        exp_rec.delete();
        for (int i = 0; i < 20; i++) begin
            s = 16'($urandom);
            if (i < 15) exp_rec.push_back(s);
            apply(1'b1, 1'b0, s);
        end
        apply(1'b0, 1'b0, 16'h0);
        wait_tick();
        check("t3_nwr", 32'(wr_log.size()), 15);
        for (int i = 0; i < 15 && i < wr_log.size(); i++)
            check("t3_wr", 32'(wr_log[i]), 32'({4'(i), exp_rec[i]}));
        check("t3_len", 32'(loop_len), 15);

        // Playback with one stalled read.
        clear_logs();
        apply(1'b0, 1'b1, 16'h0);
        apply(1'b0, 1'b1, 16'h0);
        apply(1'b0, 1'b1, 16'h0);
        check("t4_overrun_pre", 32'(overrun), 0);
        stall_next = 1'b1;
        for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 16'h0);
        apply(1'b0, 1'b0, 16'h0);
        wait_tick();
        check("t4_overrun", 32'(overrun), 1);
        check("t4_nreq", 32'(req_rises), 7);
        check("t4_nrd", 32'(rd_log.size()), 7);
        for (int i = 0; i < 7 && i < rd_log.size(); i++)
            check("t4_rd_addr", 32'(rd_log[i]), 32'(i));
        check("t4_nout", 32'(out_q.size()), 7);
        for (int i = 0; i < 7 && i < out_q.size(); i++)
            check("t4_out", 32'(out_q[i]), 32'(exp_rec[i]));
        check("t4_len_kept", 32'(loop_len), 15);

        // Reset while a write is pending, then record again.
        apply(1'b1, 1'b0, 16'h5A5A);
        @(posedge clk);
        #1;
        check("t5_req_rise", 32'(mem_req), 1);
        check("t5_req_we", 32'(mem_we), 1);
        rst = 1'b1; rec = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t5_req_drop", 32'(mem_req), 0);
        check("t5_len_clr", 32'(loop_len), 0);
        check("t5_overrun_clr", 32'(overrun), 0);
        clear_logs();
        apply(1'b1, 1'b0, 16'h1111);
        apply(1'b1, 1'b0, 16'h2222);
        apply(1'b0, 1'b0, 16'h0);
        wait_tick();
        check("t5_nwr", 32'(wr_log.size()), 2);
        if (wr_log.size() >= 2) begin
            check("t5_wr0", 32'(wr_log[0]), 32'({4'd0, 16'h1111}));
            check("t5_wr1", 32'(wr_log[1]), 32'({4'd1, 16'h2222}));
        end
        check("t5_len", 32'(loop_len), 2);

        // Random rec/play levels against a tick-level reference model.
        do_reset();
        clear_logs();
        m_mode = 0; m_len = 0; m_idx = 0; m_full = 1'b0;
        r = 1'b0; p = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(9) == 0) r = !r;
            if ($urandom_range(4) == 0) p = !p;
            s = 16'($urandom);
            apply(r, p, s);
            if (!r) m_full = 1'b0;
            if (m_mode == 0) begin
                if (r) begin
                    if (!m_full) begin
                        m_mode = 1;
                        m_list.delete();
                    end
                end else if (p && m_len != 0) begin
                    m_mode = 2;
                    m_idx  = 0;
                end
            end else if (m_mode == 1) begin
                if (!r) m_mode = 0;
            end else begin
                if (!p || r) m_mode = 0;
            end
            if (m_mode == 1) begin
                m_wr.push_back({4'(m_list.size()), s});
                m_list.push_back(s);
                m_len = m_list.size();
                if (m_len == 15) begin
                    m_mode = 0;
                    m_full = 1'b1;
                end
            end else if (m_mode == 2) begin
                m_out.push_back(m_list[m_idx]);
                m_idx = (m_idx + 1) % m_len;
            end
        end
        apply(1'b0, 1'b0, 16'h0);
        wait_tick();
        check("rnd_nwr", 32'(wr_log.size()), 32'(m_wr.size()));
        for (int i = 0; i < m_wr.size() && i < wr_log.size(); i++)
            check("rnd_wr", 32'(wr_log[i]), 32'(m_wr[i]));
        check("rnd_nout", 32'(out_q.size()), 32'(m_out.size()));
        for (int i = 0; i < m_out.size() && i < out_q.size(); i++)
            check("rnd_out", 32'(out_q[i]), 32'(m_out[i]));
        check("rnd_len", 32'(loop_len), 32'(m_len));
        check("rnd_overrun", 32'(overrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/loop_recorder.md
# loop_recorder

Sample-rate record/loop-playback sequencer between the summed synthesizer signal and the asynchronous RAM controller. While `rec` is held it writes one 16-bit sample per sample tick into consecutive RAM addresses. While `play` is held it reads the recorded loop back at the same rate, wrapping at the recorded length. Read samples are presented to the audio output stage. RAM access uses a single outstanding request/acknowledge handshake to the RAM controller.

## Interface
- `ADDR_W`, 23, RAM word-address width
- `SAMPLE_W`, 16, sample width
- `DIV`, 2268, clk cycles per sample tick (100 MHz / 2268 ≈ 44.1 kHz); must be ≥ 4

- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  synchronous, active-high reset
- `rec`  in  1  record enable, level, already debounced
- `play`  in  1  playback enable, level, already debounced
- `sig_in`  in  SAMPLE_W  live summed signal
- `mem_req`  out  1  RAM request, held until `mem_ack`
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`
- `mem_addr`  out  ADDR_W  word address; valid while `mem_req`
- `mem_wdata`  out  SAMPLE_W  write data; valid while `mem_req`
- `mem_ack`  in  1  one-cycle completion pulse from the RAM controller
- `mem_rdata`  in  SAMPLE_W  read data, valid in the `mem_ack` cycle
- `sample_out`  out  SAMPLE_W  current playback sample, held between updates
- `sample_valid`  out  1  one-cycle pulse when `sample_out` updates
- `loop_len`  out  ADDR_W  number of recorded samples
- `overrun`  out  1  sticky: a tick arrived while a request was outstanding

## Operation
- Tick generator: counter runs 0..DIV-1; `tick` is asserted in the cycle where the count equals DIV-1. The counter wraps to 0 and free-runs in every state.
- States:
  - IDLE: `sample_out` = 0.
  - RECORD.
  - PLAY.
- Mode selection is evaluated only in `tick` cycles with no request outstanding; `rec` has priority over `play`.
  - IDLE → RECORD on `rec`: `wr_addr` := 0, `loop_len` := 0, then the tick's write is issued.
  - IDLE → PLAY on `play` && !`rec` && `loop_len` ≠ 0: `rd_addr` := 0, then the tick's read is issued.
  - RECORD → IDLE on !`rec`: no write is issued on that tick.
  - PLAY → IDLE on !`play` or `rec`. A `rec` that causes this transition is acted on at the next tick.
- RECORD, per tick:
  - Capture `sig_in` into `mem_wdata`; request a write at `wr_addr`.
  - On `mem_ack`: `wr_addr`++, `loop_len` := `wr_addr`+1.
  - Full: when `loop_len` reaches 2^ADDR_W−1, return to IDLE on that ack; further ticks are ignored.
- PLAY, per tick:
  - Request a read at `rd_addr`.
  - On `mem_ack`: `sample_out` := `mem_rdata`, pulse `sample_valid`.
  - `rd_addr` := (`rd_addr`+1 == `loop_len`) ? 0 : `rd_addr`+1.
- Handshake:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable from request rise until and including the ack cycle. `mem_req` drops in the cycle after the ack.
  - A stray `mem_ack` with no request outstanding is ignored.
- Overrun: a `tick` while `mem_req` = 1 sets `overrun`, and that tick is dropped. It is cleared only by `rst`.
- `loop_len` persists across IDLE/PLAY and is cleared only by entering RECORD or by `rst`.

## Timing
- Reset values: all outputs 0, state IDLE, tick counter 0, both addresses 0.
- `rst` mid-request drops `mem_req` in the next cycle. The RAM controller tolerates an abandoned request.
- `mem_req` rises in the cycle after `tick`.
- `sample_out` and `sample_valid` update in the cycle after `mem_ack`. Read latency from tick is 2 + RAM controller latency.
- Only one request is in flight at a time; throughput is at most one access per tick.
- `sig_in` is sampled in the `tick` cycle.

## Structure
- Shared package `synth_pkg`: state enum `lr_state_t` {IDLE, RECORD, PLAY}, plus default constants `SAMPLE_W` = 16, `ADDR_W` = 23, `TICK_DIV_44K1` = 2268.
- Sub-module `sample_tick` (parameter DIV; ports clk, rst, tick) is reused later by the output stage.
- All remaining logic (FSM, address counters, request register) lives in `loop_recorder`.

## Test plan
Bench settings: DIV = 8, ADDR_W = 4, and a RAM model that acks 3 cycles after request.
- Record 5 ticks with `sig_in` = 0x1000+n, then drop `rec` → writes to addresses 0..4 with data 0x1000..0x1004; `loop_len` = 5; IDLE.
- `play` held for 12 ticks after that recording → `sample_valid` pulses carry 0x1000..0x1004, 0x1000..0x1004, 0x1000, 0x1001; `mem_addr` wraps 4 → 0.
- `play` with `loop_len` = 0 after reset → no `mem_req`; `sample_out` stays 0; state stays IDLE.
- Hold `rec` for 20 ticks → exactly 15 writes to addresses 0..14; `loop_len` = 15; IDLE after the 15th ack.
- RAM model stalls acks for 10 cycles during PLAY → `overrun` = 1, exactly one request outstanding, address advances once per ack.
- Assert `rst` while a write is pending, then `rec` → `mem_req` drops next cycle; recording restarts at address 0 with `loop_len` = 0.
